// File: rtl/led_frame_sequencer_pkg.sv
// Definitions shared by the LED output chain: sequencer states, GRB word width and
// default strip geometry, common to the sequencer, the encoder and the framebuffer.
package led_frame_sequencer_pkg;

    localparam int GRB_WIDTH            = 24;
    localparam int DEFAULT_NUM_LEDS     = 150;
    localparam int DEFAULT_LATCH_CYCLES = 600;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        CAPTURE  = 3'd2,
        SEND     = 3'd3,
        WAIT_ENC = 3'd4,
        LATCH    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/led_frame_sequencer_pulse_edge_detect.sv
// Registered rising-edge detector. RESET_VALUE presets the previous-level register, so a
// line that is already high when reset is released does not produce a pulse.
module pulse_edge_detect #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic previous_level;

    // NOTE: clocked state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            previous_level <= RESET_VALUE;
            pulse          <= 1'b0;
        end else begin
            previous_level <= level;
            pulse          <= level & ~previous_level;
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer: on each framerate edge, fetch every GRB word from the framebuffer,
// hand it to the bit encoder, then hold the line idle for the latch gap and pulse done.
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int NUM_LEDS     = DEFAULT_NUM_LEDS,
    parameter int INDEX_WIDTH  = 8,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter int LATCH_WIDTH  = 10
) (
    input  logic                   clock_12mhz,
    input  logic                   reset,
    input  logic                   framerate,
    output logic                   ram_read_enable,
    output logic [INDEX_WIDTH-1:0] ram_address,
    input  logic [GRB_WIDTH-1:0]   ram_data,
    output logic                   encoder_start,
    output logic [GRB_WIDTH-1:0]   encoder_data,
    input  logic                   encoder_finished,
    output logic [INDEX_WIDTH-1:0] led_index,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_overrun
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_LEDS - 1);
    localparam logic [LATCH_WIDTH-1:0] LATCH_LAST = LATCH_WIDTH'(LATCH_CYCLES - 1);

    seq_state_t             state;
    seq_state_t             state_next;
    logic                   frame_request;
    logic [LATCH_WIDTH-1:0] latch_count;
    logic                   last_led;
    logic                   latch_end;

    // Previous level resets high: a framerate already high at reset release is not an edge.
    pulse_edge_detect #(
        .RESET_VALUE(1'b1)
    ) u_framerate_edge (
        .clk  (clock_12mhz),
        .rst  (reset),
        .level(framerate),
        .pulse(frame_request)
    );

    assign last_led    = (led_index == LAST_INDEX);
    assign latch_end   = (latch_count == LATCH_LAST);
    assign ram_address = led_index;

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (frame_request) state_next = FETCH;
            FETCH:    state_next = CAPTURE;
            CAPTURE:  state_next = SEND;
            SEND:     state_next = WAIT_ENC;
            WAIT_ENC: if (encoder_finished) state_next = last_led ? LATCH : FETCH;
            LATCH:    if (latch_end) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the state, so an asynchronous reset clears them at once.
    always_comb begin
        ram_read_enable = 1'b0;
        encoder_start   = 1'b0;
        done            = 1'b0;
        busy            = (state != IDLE);
        frame_overrun   = frame_request & (state != IDLE);
        case (state)
            FETCH:   ram_read_enable = 1'b1;
            SEND:    encoder_start   = 1'b1;
            LATCH:   done            = latch_end;
            default: ;
        endcase
    end

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            led_index    <= '0;
            latch_count  <= '0;
            encoder_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_request) led_index <= '0;
                end
                CAPTURE: begin
                    encoder_data <= ram_data;
                end
                WAIT_ENC: begin
                    if (encoder_finished) begin
                        if (last_led) begin
                            latch_count <= '0;
                        end else begin
                            led_index <= led_index + INDEX_WIDTH'(1);
                        end
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        led_index   <= '0;
                        latch_count <= '0;
                    end else begin
                        latch_count <= latch_count + LATCH_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: a 3-LED sequencer with RAM and encoder models, plus a 1-LED instance.
module tb_led_frame_sequencer;
    import led_frame_sequencer_pkg::*;

    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: 3 LEDs ----------------
    logic        rst, framerate, rre, estart, efin, busy, done, ovr, spur, fin_model;
    logic [7:0]  addr, idx;
    logic [23:0] rdata, edata;
    logic [23:0] mem [0:3];
    int          enc_cnt;

    led_frame_sequencer #(
        .NUM_LEDS(3), .INDEX_WIDTH(8), .LATCH_CYCLES(LAT), .LATCH_WIDTH(10)
    ) dut_a (
        .clock_12mhz(clk), .reset(rst), .framerate(framerate),
        .ram_read_enable(rre), .ram_address(addr), .ram_data(rdata),
        .encoder_start(estart), .encoder_data(edata), .encoder_finished(efin),
        .led_index(idx), .busy(busy), .done(done), .frame_overrun(ovr)
    );

    always @(posedge clk) if (rre) rdata <= mem[addr[1:0]];

    always @(posedge clk) begin
        fin_model <= 1'b0;
        if (estart) enc_cnt <= 5;
        else if (enc_cnt != 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) fin_model <= 1'b1;
        end
    end
    assign efin = fin_model | spur;

    // ---------------- instance B: 1 LED ----------------
    logic        rst_b, fr_b, rre_b, estart_b, efin_b, busy_b, done_b, ovr_b;
    logic [7:0]  addr_b, idx_b;
    logic [23:0] rdata_b, edata_b;
    int          enc_cnt_b;

    led_frame_sequencer #(
        .NUM_LEDS(1), .INDEX_WIDTH(8), .LATCH_CYCLES(LAT), .LATCH_WIDTH(10)
    ) dut_b (
        .clock_12mhz(clk), .reset(rst_b), .framerate(fr_b),
        .ram_read_enable(rre_b), .ram_address(addr_b), .ram_data(rdata_b),
        .encoder_start(estart_b), .encoder_data(edata_b), .encoder_finished(efin_b),
        .led_index(idx_b), .busy(busy_b), .done(done_b), .frame_overrun(ovr_b)
    );

    always @(posedge clk) if (rre_b) rdata_b <= 24'hABCDEF ^ {16'h0, addr_b};

    always @(posedge clk) begin
        efin_b <= 1'b0;
        if (estart_b) enc_cnt_b <= 4;
        else if (enc_cnt_b != 0) begin
            enc_cnt_b <= enc_cnt_b - 1;
            if (enc_cnt_b == 1) efin_b <= 1'b1;
        end
    end

    // ---------------- scoreboards / monitors ----------------
    logic [23:0] exp_q[$];
    logic [23:0] exp_qb[$];
    logic [23:0] exp_word;
    int  start_count = 0, done_count = 0, ovr_count = 0;
    int  fetch_idx = 0, fins_in_frame = 0, last_fin = 0;
    int  first_rre_cyc = -1, first_start_cyc = -1;
    bit  awaiting = 0;
    int  start_count_b = 0, done_count_b = 0, last_fin_b = 0;

    always @(negedge clk) begin
        if (rst) begin
            awaiting = 0; fetch_idx = 0; fins_in_frame = 0;
        end else begin
            if (rre) begin
                total++;
                if (addr !== fetch_idx[7:0]) begin
                    bad++; $display("FAIL fetch_addr: got %0d want %0d", addr, fetch_idx);
                end
                if (fetch_idx == 0) first_rre_cyc = cyc;
                fetch_idx++;
            end
            if (estart) begin
                start_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL start_unexpected: data %h with empty scoreboard", edata);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (edata !== exp_word) begin
                        bad++; $display("FAIL start_data: got %h want %h", edata, exp_word);
                    end
                end
                total++;
                if (done || rre) begin
                    bad++; $display("FAIL strobe_excl: start with done=%b rre=%b", done, rre);
                end
                if (fins_in_frame > 0) begin
                    total++;
                    if (cyc - last_fin !== 3) begin
                        bad++; $display("FAIL fin_to_start: got %0d want 3", cyc - last_fin);
                    end
                end else begin
                    first_start_cyc = cyc;
                end
                awaiting = 1;
            end
            if (efin && awaiting) begin
                awaiting = 0; last_fin = cyc; fins_in_frame++;
            end
            if (ovr) ovr_count++;
            if (done) begin
                done_count++;
                total++;
                if (fins_in_frame !== 3 || cyc - last_fin !== LAT) begin
                    bad++;
                    $display("FAIL done_timing: fins=%0d gap=%0d want fins=3 gap=%0d",
                             fins_in_frame, cyc - last_fin, LAT);
                end
                fetch_idx = 0; fins_in_frame = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            if (estart_b) begin
                start_count_b++;
                total++;
                if (exp_qb.size() == 0) begin
                    bad++; $display("FAIL b_start_unexpected: data %h", edata_b);
                end else begin
                    exp_word = exp_qb.pop_front();
                    if (edata_b !== exp_word) begin
                        bad++; $display("FAIL b_start_data: got %h want %h", edata_b, exp_word);
                    end
                end
            end
            if (efin_b) last_fin_b = cyc;
            if (done_b) begin
                done_count_b++;
                total++;
                if (cyc - last_fin_b !== LAT || estart_b) begin
                    bad++; $display("FAIL b_done_timing: gap=%0d want %0d", cyc - last_fin_b, LAT);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic start_frame(input bit expect_run, output int k0);
        @(posedge clk); #1;
        framerate = 1'b1;
        k0 = cyc;
        if (expect_run) for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
        @(posedge clk); #1;
        framerate = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = done_count;
        for (int i = 0; i < budget && done_count == n; i++) @(negedge clk);
        total++;
        if (done_count == n) begin
            bad++; $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic wait_fins(input int want, input int budget);
        for (int i = 0; i < budget && fins_in_frame < want; i++) @(negedge clk);
        total++;
        if (fins_in_frame < want) begin
            bad++; $display("FAIL fin_timeout: got %0d finished want %0d", fins_in_frame, want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; framerate = 1'b0; spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, rre, estart, ovr} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000", {busy, done, rre, estart, ovr});
        end
        total++;
        if (idx !== 8'd0 || edata !== 24'd0) begin
            bad++; $display("FAIL reset_regs: idx=%0d data=%h want 0/0", idx, edata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic_frame;
        int k0, s0;
        s0 = start_count;
        start_frame(1'b1, k0);
        wait_done_a(200);
        // framerate rises in cycle k0; the registered request is seen in k0+1
        total++;
        if (first_rre_cyc !== k0 + 2) begin
            bad++; $display("FAIL first_fetch: cycle %0d want %0d", first_rre_cyc, k0 + 2);
        end
        total++;
        if (first_start_cyc !== k0 + 4) begin
            bad++; $display("FAIL first_start: cycle %0d want %0d", first_start_cyc, k0 + 4);
        end
        total++;
        if (start_count - s0 !== 3 || exp_q.size() !== 0) begin
            bad++; $display("FAIL basic_count: starts=%0d left=%0d want 3/0",
                            start_count - s0, exp_q.size());
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL basic_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_overrun;
        int k0, s0, o0;
        s0 = start_count; o0 = ovr_count;
        start_frame(1'b1, k0);
        for (int i = 0; i < 100 && start_count - s0 < 2; i++) @(negedge clk);
        start_frame(1'b0, k0);
        wait_done_a(200);
        total++;
        if (ovr_count - o0 !== 1) begin
            bad++; $display("FAIL overrun_pulses: got %0d want 1", ovr_count - o0);
        end
        total++;
        if (start_count - s0 !== 3) begin
            bad++; $display("FAIL overrun_starts: got %0d want 3", start_count - s0);
        end
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (start_count - s0 !== 3 || busy !== 1'b0) begin
            bad++; $display("FAIL overrun_extra: starts=%0d busy=%b want 3/0", start_count - s0, busy);
        end
    endtask

    task automatic test_spurious;
        int k0, s0;
        s0 = start_count;
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || start_count !== s0) begin
            bad++; $display("FAIL spur_idle: busy=%b starts=%0d want 0/%0d", busy, start_count, s0);
        end
        start_frame(1'b1, k0);
        for (int i = 0; i < 20 && !rre; i++) @(negedge clk);
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        total++;
        if (estart !== 1'b1) begin
            bad++; $display("FAIL spur_capture: start=%b want 1", estart);
        end
        wait_fins(3, 100);
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        wait_done_a(50);
        total++;
        if (start_count - s0 !== 3) begin
            bad++; $display("FAIL spur_starts: got %0d want 3", start_count - s0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int k0, s0, d0;
        start_frame(1'b1, k0);
        wait_fins(3, 100);
        repeat (3) @(posedge clk);
        #1;
        d0 = done_count;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, rre, estart, done, ovr} !== 5'b0 || idx !== 8'd0) begin
            bad++; $display("FAIL midreset_outputs: strobes=%b idx=%0d want 0/0",
                            {busy, rre, estart, done, ovr}, idx);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (done_count !== d0) begin
            bad++; $display("FAIL midreset_done: got %0d done pulses want 0", done_count - d0);
        end
        s0 = start_count;
        start_frame(1'b1, k0);
        wait_done_a(200);
        total++;
        if (start_count - s0 !== 3 || first_rre_cyc !== k0 + 2) begin
            bad++; $display("FAIL midreset_rerun: starts=%0d fetch=%0d want 3/%0d",
                            start_count - s0, first_rre_cyc, k0 + 2);
        end
    endtask

    task automatic test_single_led;
        rst_b = 1'b1; fr_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (start_count_b !== 0 || busy_b !== 1'b0 || ovr_b !== 1'b0) begin
            bad++; $display("FAIL single_release: starts=%0d busy=%b want 0/0", start_count_b, busy_b);
        end
        fr_b = 1'b0;
        @(posedge clk); #1;
        fr_b = 1'b1;
        exp_qb.push_back(24'hABCDEF);
        for (int i = 0; i < 100 && done_count_b == 0; i++) @(negedge clk);
        total++;
        if (start_count_b !== 1 || done_count_b !== 1) begin
            bad++; $display("FAIL single_frame: starts=%0d dones=%0d want 1/1", start_count_b, done_count_b);
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (busy_b !== 1'b0 || start_count_b !== 1 || done_count_b !== 1) begin
            bad++; $display("FAIL single_after: busy=%b starts=%0d dones=%0d want 0/1/1",
                            busy_b, start_count_b, done_count_b);
        end
    endtask

    initial begin
        mem[0] = 24'h0000FF; mem[1] = 24'h00FF00; mem[2] = 24'hFF0000; mem[3] = 24'h0;
        rst_b = 1'b1; fr_b = 1'b1;
        test_reset;
        test_basic_frame;
        test_overrun;
        test_spurious;
        test_reset_mid_frame;
        test_single_led;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
